shift_req_sequencer: RTL and testbench
======================================

Name: shift_req_sequencer

Overview:
- Shares one right-shift datapath between two requesters under round-robin arbitration.
- The datapath shifts by at most STEP_MAX bits per cycle, the same granularity as the team's 2-bit shift_amt barrel shifter.
- Any requested amount is decomposed into successive passes of the shifter.
- Sits between request-issuing logic and downstream consumers, with valid/ready on both sides.

Parameters:
WIDTH, 8, data word width in bits
AMT_W, 3, width of requested shift amount (0..2^AMT_W-1)
STEP_MAX, 3, maximum shift applied per cycle by the internal shifter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 has a request
req0_ready  output  1  requester 0 request accepted this cycle
req0_data  input  WIDTH  requester 0 operand
req0_amt  input  AMT_W  requester 0 right-shift amount
req1_valid  input  1  requester 1 has a request
req1_ready  output  1  requester 1 request accepted this cycle
req1_data  input  WIDTH  requester 1 operand
req1_amt  input  AMT_W  requester 1 right-shift amount
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  WIDTH  shifted result (logical, zero fill)
res_id  output  1  requester that owns res_data
res_passes  output  AMT_W  number of shift passes used
busy  output  1  high whenever state is not IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: res_valid=0, res_data=0, res_id=0, res_passes=0, busy=0, state=IDLE, last_grant=1.
  - last_grant=1 means requester 0 wins the first contention.
- reqN_ready is combinational: (state==IDLE) && !rst && grant==N. At most one ready is high per cycle.
- Grant:
  - Only one valid: that requester wins.
  - Both valid: the requester != last_grant wins.
  - last_grant updates on every accept.
- Accept (valid && ready at a clock edge): capture data, amt and id; clear the pass counter.
  - amt==0: go to DONE.
  - amt!=0: go to SHIFT.
- SHIFT, once per cycle:
  - step = min(remaining, STEP_MAX).
  - work >>= step (zero fill); remaining -= step; passes += 1.
  - Go to DONE when remaining reaches 0.
- DONE: res_valid=1; res_data, res_id and res_passes are held stable until res_ready=1.
  - On the res_valid && res_ready edge: go to IDLE, res_valid=0.
  - A new accept is possible from the next cycle (no same-cycle turnaround).
- Latency from accept edge to res_valid high: 1 + ceil(amt/STEP_MAX) cycles.
- Amounts >= WIDTH yield 0; passes still follow the step rule. No wrap or rotate.
- Backpressure: while in SHIFT or DONE, both readys stay 0. Requests must hold valid and payload until accepted.
- reqN_valid may drop without acceptance, with no side effects.
- Reset mid-operation: next state IDLE, in-flight request discarded, all outputs return to reset values on the following edge, last_grant=1.
- Internal datapath: a case on step selecting {zeros, work[WIDTH-1:step]}. There is no combinational path from res_ready to reqN_ready.

Test Plan:
- Directed scenarios assume WIDTH=8, STEP_MAX=3.
- 1. Zero shift: req0 data=8'hB6, amt=0 → req0_ready=1 for one cycle; res_valid on the next cycle; res_data=8'hB6, res_id=0, res_passes=0.
- 2. Max shift: req1 data=8'hF0, amt=7 → three SHIFT cycles (steps 3,3,1); res_valid 4 cycles after accept; res_data=8'h01, res_id=1, res_passes=3.
- 3. Contention fairness: after reset both valid (req0 8'h80 amt 3; req1 8'hFF amt 4).
  - req0 served first → 8'h10, passes=1.
  - Then req1 → 8'h0F, passes=2.
  - Both re-asserted → req0 wins again; never two readys in one cycle.
- 4. Backpressure: req0 8'hC3 amt 6 with res_ready held low 5 cycles → res_valid stays 1 and res_data=8'h03 stays stable; both readys stay 0; result consumed when res_ready rises, then IDLE.
- 5. Reset mid-SHIFT: req1 8'hFF amt 7, rst asserted on the second SHIFT cycle → next edge: res_valid=0, busy=0, res_data=0; no result ever appears; a later lone req1 8'h0F amt 1 returns 8'h07.
- 6. Overshift with wider AMT_W=4: req0 8'hFF amt 9 → passes=3, res_data=8'h00.

Source files
------------

// File: rtl/shift_req_sequencer.sv
// Two-requester right-shift sequencer: round-robin grant, then the request's
// amount is applied in passes of at most STEP_MAX bits until a result is offered.
module shift_req_sequencer #(
    parameter int WIDTH    = 8,
    parameter int AMT_W    = 3,
    parameter int STEP_MAX = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic [AMT_W-1:0] res_passes,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [AMT_W-1:0] amt;
        logic             id;
    } req_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] work;
    logic [AMT_W-1:0] remaining;
    logic [AMT_W-1:0] passes;
    logic [AMT_W-1:0] step;
    logic [WIDTH-1:0] shifted;
    logic             id_q;
    logic             last_grant;
    logic             gnt0, gnt1;
    logic             accept;
    req_t             win;

    // On contention the requester that did not win last time is served.
    always_comb begin
        gnt1 = req1_valid && (!req0_valid || !last_grant);
        gnt0 = req0_valid && !gnt1;
    end

    assign req0_ready = (state == IDLE) && !rst && gnt0;
    assign req1_ready = (state == IDLE) && !rst && gnt1;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        if (gnt1) win = '{data: req1_data, amt: req1_amt, id: 1'b1};
        else      win = '{data: req0_data, amt: req0_amt, id: 1'b0};
    end

    // Per-pass amount; when STEP_MAX exceeds the amount range the clamp never fires.
    always_comb begin
        if (int'(remaining) < STEP_MAX) step = remaining;
        else                            step = AMT_W'(STEP_MAX);
    end

    always_comb begin
        shifted = work;
        for (int s = 1; s <= STEP_MAX; s++) begin
            if (int'(step) == s) shifted = work >> s;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (accept) state_n = (win.amt == '0) ? DONE : SHIFT;
            SHIFT: if (remaining == step) state_n = DONE;
            DONE:  if (res_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            work       <= '0;
            remaining  <= '0;
            passes     <= '0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_n;
            if (state == IDLE && accept) begin
                work       <= win.data;
                remaining  <= win.amt;
                passes     <= '0;
                id_q       <= win.id;
                last_grant <= win.id;
            end else if (state == SHIFT) begin
                work      <= shifted;
                remaining <= remaining - step;
                passes    <= passes + AMT_W'(1);
            end
        end
    end

    assign res_valid  = (state == DONE);
    assign res_data   = work;
    assign res_id     = id_q;
    assign res_passes = passes;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_shift_req_sequencer.sv
// Bench for shift_req_sequencer: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the sequencer.
module tb_shift_req_sequencer;

    localparam int WIDTH    = 8;
    localparam int AMT_W    = 3;
    localparam int STEP_MAX = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_data, req1_data, res_data;
    logic [AMT_W-1:0] req0_amt, req1_amt, res_passes;
    logic             res_valid, res_ready, res_id, busy;

    logic             d4_rst, d4_req0_valid, d4_req0_ready, d4_req1_valid, d4_req1_ready;
    logic [7:0]       d4_req0_data, d4_req1_data, d4_res_data;
    logic [3:0]       d4_req0_amt, d4_req1_amt, d4_res_passes;
    logic             d4_res_valid, d4_res_ready, d4_res_id, d4_busy;

    always #5 clk = ~clk;

    shift_req_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W), .STEP_MAX(STEP_MAX)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_amt(req0_amt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_amt(req1_amt),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
        .res_passes(res_passes), .busy(busy)
    );

    shift_req_sequencer #(.WIDTH(8), .AMT_W(4), .STEP_MAX(3)) u_dut4 (
        .clk(clk), .rst(d4_rst),
        .req0_valid(d4_req0_valid), .req0_ready(d4_req0_ready), .req0_data(d4_req0_data), .req0_amt(d4_req0_amt),
        .req1_valid(d4_req1_valid), .req1_ready(d4_req1_ready), .req1_data(d4_req1_data), .req1_amt(d4_req1_amt),
        .res_valid(d4_res_valid), .res_ready(d4_res_ready), .res_data(d4_res_data), .res_id(d4_res_id),
        .res_passes(d4_res_passes), .busy(d4_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a result is owed after ceil(amt/STEP_MAX) shift
    // cycles, its value is simply data >> amt.
    bit         m_pend  = 1'b0;
    bit         m_valid = 1'b0;
    bit         m_last  = 1'b1;
    bit         m_id    = 1'b0;
    int         m_left  = 0;
    int         m_passes = 0;
    logic [7:0] m_data  = '0;
    bit         acc0 = 1'b0, acc1 = 1'b0;
    bit         e0, e1, idle;
    int         winner, ma;
    logic [7:0] md;

    always @(negedge clk) begin
        idle = !m_pend && !m_valid;
        winner = -1;
        if (req0_valid && req1_valid) winner = (m_last == 1'b0) ? 1 : 0;
        else if (req0_valid)          winner = 0;
        else if (req1_valid)          winner = 1;
        e0 = idle && !rst && (winner == 0);
        e1 = idle && !rst && (winner == 1);
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        chk("res_valid", res_valid, m_valid);
        chk("busy", busy, m_pend || m_valid);
        if (m_valid) begin
            chk("res_data", res_data, m_data);
            chk("res_id", res_id, m_id);
            chk("res_passes", res_passes, m_passes);
        end
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        if (rst) begin
            m_pend = 1'b0; m_valid = 1'b0; m_last = 1'b1;
        end else if (m_valid) begin
            if (res_ready) m_valid = 1'b0;
        end else if (m_pend) begin
            m_left--;
            if (m_left == 0) begin m_pend = 1'b0; m_valid = 1'b1; end
        end else if (e0 || e1) begin
            ma = e1 ? int'(req1_amt) : int'(req0_amt);
            md = e1 ? req1_data : req0_data;
            m_id = e1;
            m_last = e1;
            m_passes = (ma + STEP_MAX - 1) / STEP_MAX;
            m_data = (ma >= WIDTH) ? 8'h00 : (md >> ma);
            if (m_passes == 0) m_valid = 1'b1;
            else begin m_pend = 1'b1; m_left = m_passes; end
        end
    end

    task automatic set_req(input bit id, input bit v, input logic [7:0] d, input logic [2:0] a);
        if (id) begin req1_valid = v; req1_data = d; req1_amt = a; end
        else    begin req0_valid = v; req0_data = d; req0_amt = a; end
    endtask

    task automatic wait_ready(input bit id, input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
        end
        chk({nm, "_accept"}, got, 1'b1);
    endtask

    task automatic wait_res(output int lat);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (res_valid) begin lat = i; break; end
        end
    endtask

    // Issue one request alone, then check latency and result against literals.
    task automatic do_req(input bit id, input logic [7:0] d, input logic [2:0] a,
                          input logic [7:0] ed, input int ep, input string nm);
        int lat;
        set_req(id, 1'b1, d, a);
        wait_ready(id, nm);
        @(posedge clk); #1;
        set_req(id, 1'b0, d, a);
        wait_res(lat);
        chk({nm, "_latency"}, lat, 1 + ep);
        chk({nm, "_data"}, res_data, ed);
        chk({nm, "_id"}, res_id, id);
        chk({nm, "_passes"}, res_passes, ep);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        bit got;
        rst = 1'b1; res_ready = 1'b1;
        req0_valid = 1'b0; req0_data = '0; req0_amt = '0;
        req1_valid = 1'b0; req1_data = '0; req1_amt = '0;
        d4_rst = 1'b1; d4_res_ready = 1'b1;
        d4_req0_valid = 1'b0; d4_req0_data = '0; d4_req0_amt = '0;
        d4_req1_valid = 1'b0; d4_req1_data = '0; d4_req1_amt = '0;
        @(negedge clk);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_res_data", res_data, 8'h00);
        chk("rst_res_id", res_id, 1'b0);
        chk("rst_res_passes", res_passes, 3'd0);
        @(posedge clk); #1;
        rst = 1'b0; d4_rst = 1'b0;

        do_req(1'b0, 8'hB6, 3'd0, 8'hB6, 0, "zero_shift");
        do_req(1'b1, 8'hF0, 3'd7, 8'h01, 3, "max_shift");

        // Contention right after reset: requester 0 first, then 1, then 0 again.
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        set_req(1'b0, 1'b1, 8'h80, 3'd3);
        set_req(1'b1, 1'b1, 8'hFF, 3'd4);
        wait_ready(1'b0, "fair_first");
        chk("fair_first_r1", req1_ready, 1'b0);
        @(posedge clk); #1; req0_valid = 1'b0;
        wait_res(lat);
        chk("fair_first_data", res_data, 8'h10);
        chk("fair_first_passes", res_passes, 3'd1);
        wait_ready(1'b1, "fair_second");
        @(posedge clk); #1; req1_valid = 1'b0;
        wait_res(lat);
        chk("fair_second_data", res_data, 8'h0F);
        chk("fair_second_passes", res_passes, 3'd2);
        chk("fair_second_id", res_id, 1'b1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 8'h80, 3'd3);
        set_req(1'b1, 1'b1, 8'hFF, 3'd4);
        wait_ready(1'b0, "fair_third");
        chk("fair_third_r1", req1_ready, 1'b0);
        @(posedge clk); #1; req0_valid = 1'b0;
        wait_ready(1'b1, "fair_fourth");
        @(posedge clk); #1; req1_valid = 1'b0;
        wait_res(lat);
        @(posedge clk); #1;

        // Backpressure: result must hold while the consumer stalls.
        res_ready = 1'b0;
        set_req(1'b0, 1'b1, 8'hC3, 3'd6);
        wait_ready(1'b0, "bp");
        @(posedge clk); #1;
        req0_valid = 1'b0;
        set_req(1'b1, 1'b1, 8'h55, 3'd2);
        wait_res(lat);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", res_valid, 1'b1);
            chk("bp_data", res_data, 8'h03);
            chk("bp_readys", {req0_ready, req1_ready}, 2'b00);
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1; res_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_idle_busy", busy, 1'b0);
        @(posedge clk); #1; req1_valid = 1'b0;
        wait_res(lat);
        chk("bp_next_data", res_data, 8'h15);
        @(posedge clk); #1;

        // Reset on the second shift cycle discards the request.
        set_req(1'b1, 1'b1, 8'hFF, 3'd7);
        wait_ready(1'b1, "midrst");
        @(posedge clk); #1; req1_valid = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", res_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_data", res_data, 8'h00);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("midrst_no_result", res_valid, 1'b0);
        end
        @(posedge clk); #1;
        do_req(1'b1, 8'h0F, 3'd1, 8'h07, 1, "after_rst");

        // Wider amount field: overshift yields zero, passes follow the step rule.
        d4_req0_valid = 1'b1; d4_req0_data = 8'hFF; d4_req0_amt = 4'd9;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin @(negedge clk); got = d4_req0_ready; end
        chk("over_accept", got, 1'b1);
        @(posedge clk); #1; d4_req0_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (d4_res_valid) begin lat = i; break; end
        end
        chk("over_latency", lat, 4);
        chk("over_data", d4_res_data, 8'h00);
        chk("over_passes", d4_res_passes, 4'd3);
        chk("over_id", d4_res_id, 1'b0);

        // Random traffic; requests hold until accepted or occasionally withdraw.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(0, 9) < 6);
                req0_data = 8'($urandom); req0_amt = 3'($urandom);
            end else if ($urandom_range(0, 19) == 0) req0_valid = 1'b0;
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(0, 9) < 6);
                req1_data = 8'($urandom); req1_amt = 3'($urandom);
            end else if ($urandom_range(0, 19) == 0) req1_valid = 1'b0;
            res_ready = ($urandom_range(0, 9) < 6);
            rst = ($urandom_range(0, 149) == 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
